// File: rtl/input_packet_encoder.sv
// Host-side packet source for the control-node instruction decoder.
// It streams one job (filter rows, then ifmap timestep 0, then ifmap timestep 1)
// and merges PE acknowledgements into the same output stream. Acks have priority.
module input_packet_encoder #(
   parameter int unsigned FILTER_WIDTH = 8,
   parameter int unsigned WIDTH        = 5*FILTER_WIDTH+5,
   parameter int unsigned CHUNK        = 36
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [1:0]                cfg_fil_size,
   input  logic [5:0]                cfg_if_size,
   input  logic                      fil_valid,
   output logic                      fil_ready,
   input  logic [5*FILTER_WIDTH-1:0] fil_data,
   input  logic                      if_valid,
   output logic                      if_ready,
   input  logic [CHUNK-1:0]          if_data,
   input  logic                      ack_valid,
   output logic                      ack_ready,
   input  logic [3:0]                ack_node,
   output logic                      pkt_valid,
   input  logic                      pkt_ready,
   output logic [WIDTH-1:0]          pkt_data,
   output logic                      busy,
   output logic                      done,
   output logic                      err_node
);

   localparam int unsigned REM_W = 12;
   localparam int unsigned CNT_W = 3;
   localparam int unsigned PAD_W = WIDTH-5;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      FIL  = 3'd1,
      IF0  = 3'd2,
      IF1  = 3'd3,
      FIN  = 3'd4
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [1:0]         fs_q;
   logic [5:0]         n_q;
   logic [CNT_W-1:0]   row_cnt;
   logic [REM_W-1:0]   rem;

   logic               can_load;
   logic               stream_ok;
   logic               ack_fire;
   logic               ack_legal;
   logic               fil_fire;
   logic               if_fire;
   logic               last_row;
   logic               last_chunk;
   logic [REM_W-1:0]   n_cfg_ext;
   logic [REM_W-1:0]   n_q_ext;
   logic [REM_W-1:0]   nn_cfg;
   logic [REM_W-1:0]   nn_q;
   logic [CNT_W-1:0]   fil_rows;
   logic               ts;

   // Shared handshake decode: the output register loads when empty or draining.
   assign can_load   = !rst && (!pkt_valid || pkt_ready);
   assign ack_ready  = can_load;
   assign ack_fire   = ack_valid && can_load;
   assign ack_legal  = (ack_node != 4'd3) && (ack_node != 4'd12);
   assign stream_ok  = can_load && !ack_valid;
   assign fil_fire   = fil_valid && fil_ready;
   assign if_fire    = if_valid && if_ready;

   assign n_cfg_ext  = REM_W'(cfg_if_size);
   assign n_q_ext    = REM_W'(n_q);
   assign nn_cfg     = n_cfg_ext * n_cfg_ext;
   assign nn_q       = n_q_ext * n_q_ext;
   assign fil_rows   = CNT_W'(fs_q) + CNT_W'(2);
   assign last_row   = (row_cnt == fil_rows - CNT_W'(1));
   assign last_chunk = (rem <= REM_W'(CHUNK));
   assign ts         = (state == IF1);
   assign busy       = (state != IDLE);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = FIL;
         FIL:  if (fil_fire && last_row) state_nxt = (n_q == 6'd0) ? FIN : IF0;
         IF0:  if (if_fire && last_chunk) state_nxt = IF1;
         IF1:  if (if_fire && last_chunk) state_nxt = FIN;
         FIN:  if (!pkt_valid) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Stream-side ready outputs; an accepted ack blocks both stream inputs.
   always_comb begin
      fil_ready = 1'b0;
      if_ready  = 1'b0;
      case (state)
         FIL:      fil_ready = stream_ok;
         IF0, IF1: if_ready  = stream_ok;
         default: ;
      endcase
   end

   // Job configuration, filter row counter and remaining-element counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         fs_q    <= 2'd0;
         n_q     <= 6'd0;
         row_cnt <= '0;
         rem     <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               fs_q    <= cfg_fil_size;
               n_q     <= cfg_if_size;
               row_cnt <= '0;
               rem     <= nn_cfg;
            end
            FIL: if (fil_fire) row_cnt <= row_cnt + CNT_W'(1);
            IF0: if (if_fire) rem <= last_chunk ? nn_q : rem - REM_W'(CHUNK);
            IF1: if (if_fire && !last_chunk) rem <= rem - REM_W'(CHUNK);
            default: ;
         endcase
      end
   end

   // Single output register with ack > filter > ifmap priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_valid <= 1'b0;
         pkt_data  <= '0;
      end else if (can_load) begin
         if (ack_fire && ack_legal) begin
            pkt_valid <= 1'b1;
            pkt_data  <= {PAD_W'(0), ack_node, 1'b0};
         end else if (fil_fire) begin
            pkt_valid <= 1'b1;
            pkt_data  <= {fil_data, fs_q, 3'b011};
         end else if (if_fire) begin
            pkt_valid <= 1'b1;
            pkt_data  <= {if_data, n_q, ts, 2'b01};
         end else begin
            pkt_valid <= 1'b0;
         end
      end
   end

   // Completion pulse and sticky illegal-node flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         done     <= 1'b0;
         err_node <= 1'b0;
      end else begin
         done <= (state == FIN) && !pkt_valid;
         if (ack_fire && !ack_legal) err_node <= 1'b1;
      end
   end

endmodule

// File: tb/tb_input_packet_encoder.sv
// Directed bench for input_packet_encoder: ack format table, job table, reset-mid-job sequence.
module tb_input_packet_encoder;

   localparam int unsigned FW = 8;
   localparam int unsigned W  = 5*FW+5;
   localparam int unsigned CH = 36;
   localparam int unsigned FB = 5*FW;

   logic          clk = 1'b0;
   logic          rst, start;
   logic [1:0]    cfg_fil_size;
   logic [5:0]    cfg_if_size;
   logic          fil_valid, fil_ready;
   logic [FB-1:0] fil_data;
   logic          if_valid, if_ready;
   logic [CH-1:0] if_data;
   logic          ack_valid, ack_ready;
   logic [3:0]    ack_node;
   logic          pkt_valid, pkt_ready;
   logic [W-1:0]  pkt_data;
   logic          busy, done, err_node;

   int vec_cnt  = 0;
   int miss_cnt = 0;

   logic [W-1:0] sq[$];
   logic [W-1:0] aq[$];

   input_packet_encoder #(.FILTER_WIDTH(FW), .WIDTH(W), .CHUNK(CH)) dut (
      .clk(clk), .rst(rst), .start(start),
      .cfg_fil_size(cfg_fil_size), .cfg_if_size(cfg_if_size),
      .fil_valid(fil_valid), .fil_ready(fil_ready), .fil_data(fil_data),
      .if_valid(if_valid), .if_ready(if_ready), .if_data(if_data),
      .ack_valid(ack_valid), .ack_ready(ack_ready), .ack_node(ack_node),
      .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data),
      .busy(busy), .done(done), .err_node(err_node)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [FB-1:0] fil_pat(input int r);
      return {8'hC3, 8'(r), 8'(r+7), 8'(r*3), 8'(r ^ 5)};
   endfunction

   function automatic logic [CH-1:0] if_pat(input int t, input int c);
      return {4'(t+9), 8'(c), 24'hA55A00 ^ 24'(c*17)};
   endfunction

   task automatic idle_inputs();
      start = 1'b0; cfg_fil_size = 2'd0; cfg_if_size = 6'd0;
      fil_valid = 1'b0; fil_data = '0; if_valid = 1'b0; if_data = '0;
      ack_valid = 1'b0; ack_node = 4'd0; pkt_ready = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("reset_outs", W'({pkt_valid, busy, done, err_node, fil_ready, if_ready, ack_ready}), '0);
      rst = 1'b0;
   endtask

   // Runs one job while modelling the expected stream and ack packet sequences.
   task automatic run_job(input int fs, input int n, input int rows, input int cpp,
                          input int bp, input int ackm);
      int rows_sent = 0, chunks_sent = 0, dones = 0, t = 0;
      logic finished = 1'b0, hold_v = 1'b0;
      logic [W-1:0] hold_d = '0, exp_d;
      sq.delete(); aq.delete();
      for (int r = 0; r < rows; r++) sq.push_back({fil_pat(r), 2'(fs), 3'b011});
      for (int s = 0; s < 2; s++)
         for (int c = 0; c < cpp; c++) sq.push_back({if_pat(s, c), 6'(n), 1'(s), 2'b01});
      for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
         @(negedge clk);
         start        = (cyc == 0) || (cyc == 5);
         cfg_fil_size = (cyc == 0) ? 2'(fs) : ~2'(fs);
         cfg_if_size  = (cyc == 0) ? 6'(n) : 6'(n+1);
         pkt_ready    = (bp != 0) ? (cyc % 2 == 0) : 1'b1;
         ack_valid    = (ackm != 0) && (cyc < 24) && (cyc % 3 != 2);
         ack_node     = 4'(cyc);
         fil_valid    = 1'b1;
         if_valid     = (cyc % 7 != 3);
         fil_data     = fil_pat(rows_sent);
         t            = (chunks_sent >= cpp) ? 1 : 0;
         if_data      = if_pat(t, chunks_sent - t*cpp);
         #1;
         if (hold_v) chk("stall_stable", W'({pkt_valid, pkt_data}), W'({1'b1, hold_d}));
         if (cyc == 1) chk("busy_run", W'(busy), W'(1));
         chk("rdy_excl", W'(fil_ready & if_ready), '0);
         if (ack_valid && ack_ready) chk("ack_prio", W'({fil_ready, if_ready}), '0);
         if (pkt_valid && pkt_ready) begin
            if (pkt_data[0] == 1'b0) begin
               if (aq.size() == 0) chk("ack_extra", pkt_data, '1);
               else begin exp_d = aq.pop_front(); chk("ack_pkt", pkt_data, exp_d); end
            end else begin
               if (sq.size() == 0) chk("stream_extra", pkt_data, '1);
               else begin exp_d = sq.pop_front(); chk("stream_pkt", pkt_data, exp_d); end
            end
         end
         if (ack_valid && ack_ready && ack_node != 4'd3 && ack_node != 4'd12)
            aq.push_back({40'd0, ack_node, 1'b0});
         if (fil_valid && fil_ready) rows_sent++;
         if (if_valid && if_ready) chunks_sent++;
         if (done) begin
            dones++;
            finished = 1'b1;
            chk("done_drain", W'(sq.size()), '0);
            chk("done_idle", W'(busy), '0);
         end
         hold_v = pkt_valid && !pkt_ready;
         hold_d = pkt_data;
      end
      if (!finished) chk("job_timeout", W'(dones), W'(1));
      chk("rows_sent", W'(rows_sent), W'(rows));
      chk("chunks_sent", W'(chunks_sent), W'(2*cpp));
      @(negedge clk);
      idle_inputs();
      #1;
      chk("done_pulse", W'({done, fil_ready, if_ready}), '0);
      if (ackm != 0) begin
         chk("ack_drain", W'(aq.size()), '0);
         chk("err_sticky", W'(err_node), W'(1));
      end
   endtask

   typedef struct {
      logic [3:0]   node;
      logic         exp_v;
      logic [W-1:0] exp_d;
      logic         exp_err;
   } ack_vec_t;

   typedef struct {
      int fs; int n; int rows; int cpp; int bp; int ackm;
   } job_vec_t;

   ack_vec_t av[6];
   job_vec_t jv[7];

   initial begin
      av[0] = '{4'd5,  1'b1, 45'h00A, 1'b0};
      av[1] = '{4'd0,  1'b1, 45'h000, 1'b0};
      av[2] = '{4'd15, 1'b1, 45'h01E, 1'b0};
      av[3] = '{4'd12, 1'b0, 45'h000, 1'b1};
      av[4] = '{4'd7,  1'b1, 45'h00E, 1'b1};
      av[5] = '{4'd3,  1'b0, 45'h000, 1'b1};

      jv[0] = '{1, 6,  3, 1,   0, 0};
      jv[1] = '{0, 13, 2, 5,   1, 0};
      jv[2] = '{1, 13, 3, 5,   1, 1};
      jv[3] = '{3, 0,  5, 0,   0, 0};
      jv[4] = '{2, 36, 4, 36,  1, 0};
      jv[5] = '{1, 63, 3, 111, 0, 0};
      jv[6] = '{0, 1,  2, 1,   1, 0};

      idle_inputs();
      rst = 1'b1;
      do_reset();

      // Ack format and illegal-node table, applied from IDLE.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         ack_valid = 1'b1; ack_node = av[i].node; pkt_ready = 1'b1;
         #1;
         chk("ack_ready", W'(ack_ready), W'(1));
         @(negedge clk);
         ack_valid = 1'b0;
         #1;
         chk("ack_valid", W'(pkt_valid), W'(av[i].exp_v));
         if (av[i].exp_v) chk("ack_data", pkt_data, av[i].exp_d);
         chk("ack_err", W'(err_node), W'(av[i].exp_err));
         chk("ack_busy", W'(busy), '0);
      end
      do_reset();

      for (int j = 0; j < 7; j++)
         run_job(jv[j].fs, jv[j].n, jv[j].rows, jv[j].cpp, jv[j].bp, jv[j].ackm);

      // Reset during IF0 with an ifmap packet held in the output register.
      begin
         logic seen = 1'b0;
         @(negedge clk);
         start = 1'b1; cfg_fil_size = 2'd0; cfg_if_size = 6'd13;
         fil_valid = 1'b1; fil_data = fil_pat(0);
         if_valid = 1'b1; if_data = if_pat(0, 0); pkt_ready = 1'b1;
         for (int cyc = 0; cyc < 50 && !seen; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (if_valid && if_ready) seen = 1'b1;
         end
         chk("rst_reach_if0", W'(seen), W'(1));
         @(negedge clk);
         pkt_ready = 1'b0;
         #1;
         chk("rst_pending", W'({pkt_valid, pkt_data[1:0]}), W'(3'b101));
         rst = 1'b1;
         @(negedge clk);
         #1;
         chk("rst_midjob", W'({pkt_valid, busy}), '0);
         rst = 1'b0;
         idle_inputs();
      end
      run_job(0, 13, 2, 5, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule

// File: doc/input_packet_encoder.md
Name: input_packet_encoder

Overview:
- Host-side source of the 45-bit input packets consumed by the control-node instruction decoder.
- Holds a per-layer configuration, then streams one job in order: the filter rows, all ifmap chunks for timestep 0, then all ifmap chunks for timestep 1.
- Also formats PE acknowledgements into ack packets and merges them into the same output stream with priority.
- Clocked; sits between host/testbench memories and the NoC injection port of the control node.

Parameters:
- FILTER_WIDTH, 8, bits per filter weight.
- WIDTH, 5*FILTER_WIDTH+5 (45), packet width.
- CHUNK, 36, ifmap bits per ifmap packet; must equal WIDTH-9.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; latches cfg_* and begins a job; ignored while busy=1.
- cfg_fil_size  in  2  filter size code; rows = code+2.
- cfg_if_size  in  6  ifmap side length N.
- fil_valid  in  1  filter row available.
- fil_ready  out  1  filter row accepted this cycle.
- fil_data  in  5*FILTER_WIDTH  one filter row; weight 0 in LSBs, zero-padded.
- if_valid  in  1  ifmap chunk available.
- if_ready  out  1  ifmap chunk accepted this cycle.
- if_data  in  CHUNK  36 ifmap spikes; element 0 in the LSB.
- ack_valid  in  1  PE ack request.
- ack_ready  out  1  ack accepted this cycle.
- ack_node  in  4  PE node id.
- pkt_valid  out  1  output packet valid.
- pkt_ready  in  1  downstream accepts.
- pkt_data  out  WIDTH  output packet.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse when a job finishes.
- err_node  out  1  sticky; set when an ack is dropped for an illegal node id.

Behaviour:
- Reset (synchronous): all outputs 0, state IDLE, output register empty, all counters 0. Reset mid-job abandons the job with no further packets; a packet pending in the output register is discarded.
- Handshakes: a transfer occurs on any valid&ready cycle. pkt_valid/pkt_data stay stable until pkt_ready. The single output register loads only when it is empty or being drained in the same cycle (full throughput, one packet per cycle).
- Packet formats:
  - Filter: [44:5]=fil_data, [4:3]=cfg_fil_size, [2]=0, [1]=1, [0]=1.
  - Ifmap: [44:9]=if_data, [8:3]=N, [2]=timestep, [1]=0, [0]=1.
  - Ack: [44:5]=0, [4:1]=ack_node, [0]=0.
- Ack path:
  - Ack has priority over stream packets when both want the output register in the same cycle.
  - ack_ready=1 whenever the register can load.
  - ack_node 3 or 12: accepted, not forwarded, err_node set. err_node clears only on rst.
  - Acks are accepted in any state, including IDLE.
- FSM:
  - IDLE: busy=0. On start, latch the configuration, set row_cnt=0 and rem=N*N (12-bit), go to FIL.
  - FIL: fil_ready=1 only when the register can load and no ack is accepted this cycle. On each accepted row, row_cnt++. When row_cnt reaches cfg_fil_size+2 rows, go to IF0; if N=0, go to FIN instead.
  - IF0 / IF1: same gating rule on if_ready; timestep bit is 0 in IF0 and 1 in IF1. On each accepted chunk, rem = rem-36 if rem>36, else the phase ends. IF0 ends -> reload rem=N*N, go to IF1. IF1 ends -> FIN.
  - Chunks per phase = ceil(N*N/36), at most 111.
  - FIN: wait until the output register is empty (last packet drained), then pulse done for one cycle and go to IDLE. busy=1 in FIL, IF0, IF1 and FIN.
- start during busy is ignored; the configuration is not re-latched.
- fil_ready and if_ready are never asserted in the same cycle. Neither is asserted in IDLE or FIN.
- Latency: input handshake to pkt_valid is 1 cycle.

Test Plan:
- Ack only: rst, ack_node=5, pkt_ready=1 -> next cycle pkt_data=0x00...0A, pkt_valid=1; busy stays 0.
- Illegal ack: ack_node=12 -> no pkt_valid, err_node=1 and stays 1 until rst.
- 3x3 filter with 6x6 ifmap: cfg_fil_size=1, N=6 -> 3 filter packets with [4:0]=0b01011; then 1 ifmap packet with [8:0]=0x031; then 1 with [8:0]=0x035; done pulses after the 5th packet drains.
- Multi-chunk ifmap: N=13 (169 elements) -> 5 chunks per timestep, 10 ifmap packets total; timestep bit switches after the 5th.
- Backpressure plus contention: pkt_ready toggled 1/0 and ack_valid held high during FIL -> pkt_data stable while stalled; acks win every contested cycle; no filter row lost or duplicated; row order preserved.
- Reset mid-job: assert rst during IF0 with a packet pending -> pkt_valid=0, busy=0 the next cycle; a new start runs the full sequence from filter row 0.
